// File: rtl/hog_svm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hog_svm_pkg
// Brief    : Shared widths, saturation limits and FSM state encoding for the
//            HOG block SVM multiply-accumulate stage.
// Revision : 1.0 - initial release
// ============================================================================
package hog_svm_pkg;

  localparam int BID_W  = 13;
  localparam int FEA_I  = 4;
  localparam int FEA_F  = 28;
  localparam int W_I    = 2;
  localparam int W_F    = 14;
  localparam int ACC_I  = 8;
  localparam int ACC_F  = 24;

  localparam int FEA_W  = FEA_I + FEA_F;
  localparam int W_W    = W_I + W_F;
  localparam int ACC_W  = ACC_I + ACC_F;
  localparam int SHIFT  = FEA_F + W_F - ACC_F;
  localparam int N_BIN  = 9;
  localparam int N_CELL = 4;

  // Signed product of zero-extended feature and signed weight.
  localparam int PROD_W = FEA_W + W_W + 1;
  // Nine-lane sum with guard bits.
  localparam int SUM_W  = PROD_W + 4;
  // Four-cell accumulation with extra guard bits so nothing wraps.
  localparam int ACCX_W = SUM_W + 2;

  localparam logic signed [ACC_W-1:0] SCORE_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SCORE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MAC0  = 3'd2,
    S_MAC1  = 3'd3,
    S_MAC2  = 3'd4,
    S_MAC3  = 3'd5,
    S_OUT   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hog_svm_block_mac_svm_mac9.sv
`default_nettype none
// ============================================================================
// Module   : svm_mac9
// Brief    : Combinational 9-lane feature x weight multiply, floor rescale to
//            score precision, and lane summation for one cell.
// Revision : 1.0 - initial release
// ============================================================================
module svm_mac9
  import hog_svm_pkg::*;
(
  input  logic [N_BIN*FEA_W-1:0]  i_fea,
  input  logic [N_BIN*W_W-1:0]    i_wt,
  output logic signed [SUM_W-1:0] o_sum
);

  logic signed [PROD_W-1:0] w_lane [N_BIN];

  for (genvar j = 0; j < N_BIN; j++) begin : g_lane
    logic signed [PROD_W-1:0] w_fx;
    logic signed [PROD_W-1:0] w_wx;
    logic signed [PROD_W-1:0] w_prod;
    // Features are unsigned: zero-extend. Weights are signed: sign-extend.
    assign w_fx      = {{(W_W+1){1'b0}}, i_fea[j*FEA_W +: FEA_W]};
    assign w_wx      = {{(FEA_W+1){i_wt[j*W_W+W_W-1]}}, i_wt[j*W_W +: W_W]};
    assign w_prod    = w_fx * w_wx;
    // Arithmetic shift floors negative products toward -inf.
    assign w_lane[j] = w_prod >>> SHIFT;
  end

  // Sum the nine rescaled lanes into the guarded cell partial.
  always_comb begin
    o_sum = '0;
    for (int j = 0; j < N_BIN; j++) begin
      o_sum = o_sum + SUM_W'(w_lane[j]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hog_svm_block_mac.sv
`default_nettype none
// ============================================================================
// Module   : hog_svm_block_mac
// Brief    : Captures one 2x2-cell HOG block, fetches its 36 SVM weights from
//            a synchronous ROM, and accumulates the signed dot product one cell
//            per cycle. Emits a saturated per-block score with its block id.
// Revision : 1.0 - initial release
// ============================================================================
module hog_svm_block_mac
  import hog_svm_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BID_W-1:0]               bid,
  input  logic [N_BIN*FEA_W-1:0]         fea_a,
  input  logic [N_BIN*FEA_W-1:0]         fea_b,
  input  logic [N_BIN*FEA_W-1:0]         fea_c,
  input  logic [N_BIN*FEA_W-1:0]         fea_d,
  input  logic                           i_valid,
  output logic [BID_W-1:0]               w_addr,
  output logic                           w_en,
  input  logic [N_CELL*N_BIN*W_W-1:0]    w_data,
  output logic [ACC_W-1:0]               o_score,
  output logic [BID_W-1:0]               o_bid,
  output logic                           o_valid,
  output logic                           ovf,
  output logic                           sat
);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic                            w_accept;
  logic                            w_drop;

  logic [BID_W-1:0]                r_bid;
  logic [N_BIN*FEA_W-1:0]          r_fea_a;
  logic [N_BIN*FEA_W-1:0]          r_fea_b;
  logic [N_BIN*FEA_W-1:0]          r_fea_c;
  logic [N_BIN*FEA_W-1:0]          r_fea_d;
  logic [N_CELL*N_BIN*W_W-1:0]     r_w;
  logic signed [ACCX_W-1:0]        r_acc;
  logic [ACC_W-1:0]                r_score;
  logic [BID_W-1:0]                r_obid;
  logic                            r_ovf;
  logic                            r_sat;

  logic [N_CELL*N_BIN*W_W-1:0]     w_wsrc;
  logic [N_BIN*FEA_W-1:0]          w_cell_fea;
  logic [N_BIN*W_W-1:0]            w_cell_wt;
  logic signed [SUM_W-1:0]         w_part;
  logic signed [ACCX_W-1:0]        w_final;
  logic                            w_hi;
  logic                            w_lo;
  logic [ACC_W-1:0]                w_score_sat;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state sequencing plus capture/drop decode and strobe outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_en        = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_en        = 1'b1;
        w_drop      = i_valid;
        w_state_nxt = S_MAC0;
      end
      S_MAC0: begin
        w_drop      = i_valid;
        w_state_nxt = S_MAC1;
      end
      S_MAC1: begin
        w_drop      = i_valid;
        w_state_nxt = S_MAC2;
      end
      S_MAC2: begin
        w_drop      = i_valid;
        w_state_nxt = S_MAC3;
      end
      S_MAC3: begin
        w_drop      = i_valid;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        o_valid = 1'b1;
        if (i_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Cell select: MAC0 uses the ROM word directly, later cycles use its copy.
  always_comb begin
    w_wsrc     = (r_state == S_MAC0) ? w_data : r_w;
    w_cell_fea = r_fea_a;
    w_cell_wt  = w_wsrc[0*N_BIN*W_W +: N_BIN*W_W];
    case (r_state)
      S_MAC1: begin
        w_cell_fea = r_fea_b;
        w_cell_wt  = w_wsrc[1*N_BIN*W_W +: N_BIN*W_W];
      end
      S_MAC2: begin
        w_cell_fea = r_fea_c;
        w_cell_wt  = w_wsrc[2*N_BIN*W_W +: N_BIN*W_W];
      end
      S_MAC3: begin
        w_cell_fea = r_fea_d;
        w_cell_wt  = w_wsrc[3*N_BIN*W_W +: N_BIN*W_W];
      end
      default: ;
    endcase
  end

  svm_mac9 u_mac9 (
    .i_fea (w_cell_fea),
    .i_wt  (w_cell_wt),
    .o_sum (w_part)
  );

  // Running sum including the current cell, and its clamp to score range.
  always_comb begin
    w_final     = r_acc + ACCX_W'(w_part);
    w_hi        = (w_final > ACCX_W'(SCORE_MAX));
    w_lo        = (w_final < ACCX_W'(SCORE_MIN));
    w_score_sat = w_final[ACC_W-1:0];
    if (w_hi)      w_score_sat = SCORE_MAX;
    else if (w_lo) w_score_sat = SCORE_MIN;
  end

  // Block capture, accumulation, result registers and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bid   <= '0;
      r_fea_a <= '0;
      r_fea_b <= '0;
      r_fea_c <= '0;
      r_fea_d <= '0;
      r_w     <= '0;
      r_acc   <= '0;
      r_score <= '0;
      r_obid  <= '0;
      r_ovf   <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bid   <= bid;
        r_fea_a <= fea_a;
        r_fea_b <= fea_b;
        r_fea_c <= fea_c;
        r_fea_d <= fea_d;
        r_acc   <= '0;
      end
      if (w_drop) r_ovf <= 1'b1;
      case (r_state)
        S_MAC0: begin
          r_w   <= w_data;
          r_acc <= w_final;
        end
        S_MAC1, S_MAC2: r_acc <= w_final;
        S_MAC3: begin
          r_score <= w_score_sat;
          r_obid  <= r_bid;
          if (w_hi || w_lo) r_sat <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_addr  = r_bid;
  assign o_score = r_score;
  assign o_bid   = r_obid;
  assign ovf     = r_ovf;
  assign sat     = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_hog_svm_block_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_hog_svm_block_mac
// Brief    : Directed self-checking bench for hog_svm_block_mac with a
//            one-cycle-latency weight ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hog_svm_block_mac;

  logic         clk = 1'b0;
  logic         rst;
  logic [12:0]  bid;
  logic [287:0] fea_a, fea_b, fea_c, fea_d;
  logic         i_valid;
  logic [12:0]  w_addr;
  logic         w_en;
  logic [575:0] w_data;
  logic [31:0]  o_score;
  logic [12:0]  o_bid;
  logic         o_valid;
  logic         ovf;
  logic         sat;

  logic [575:0] rom_word;
  int total = 0;
  int bad   = 0;

  localparam logic [287:0] F_ONE  = {9{32'h10000000}};
  localparam logic [575:0] W_ONE  = {36{16'h4000}};

  hog_svm_block_mac dut (
    .clk     (clk),
    .rst     (rst),
    .bid     (bid),
    .fea_a   (fea_a),
    .fea_b   (fea_b),
    .fea_c   (fea_c),
    .fea_d   (fea_d),
    .i_valid (i_valid),
    .w_addr  (w_addr),
    .w_en    (w_en),
    .w_data  (w_data),
    .o_score (o_score),
    .o_bid   (o_bid),
    .o_valid (o_valid),
    .ovf     (ovf),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (w_en) w_data <= rom_word;
  end

  task automatic set_fea(input logic [287:0] fa, fb, fc, fd);
    fea_a = fa; fea_b = fb; fea_c = fc; fea_d = fd;
  endtask

  task automatic run_block(input logic [12:0] b, input logic [287:0] fa, fb, fc, fd,
                           input logic [575:0] wd, input logic [31:0] es,
                           input logic esat, input string nm);
    rom_word = wd;
    bid      = b;
    set_fea(fa, fb, fc, fd);
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid  = 1'b0;
    total++;
    if (w_en !== 1'b1 || w_addr !== b) begin
      bad++;
      $display("FAIL %s_fetch: w_en=%0b w_addr=%0d want w_en=1 w_addr=%0d", nm, w_en, w_addr, b);
    end
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      total++;
      if (o_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s_early_valid: cycle T+%0d o_valid=%0b want 0", nm, k, o_valid);
      end
    end
    @(posedge clk); #1;
    total++;
    if (o_valid !== 1'b1 || o_score !== es || o_bid !== b || sat !== esat) begin
      bad++;
      $display("FAIL %s_result: valid=%0b score=%h bid=%0d sat=%0b want 1 %h %0d %0b",
               nm, o_valid, o_score, o_bid, sat, es, b, esat);
    end
    @(posedge clk); #1;
    total++;
    if (o_valid !== 1'b0 || o_score !== es) begin
      bad++;
      $display("FAIL %s_hold: valid=%0b score=%h want 0 %h", nm, o_valid, o_score, es);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; bid = '0; rom_word = '0;
    set_fea('0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_score, o_bid, o_valid, w_en, w_addr, ovf, sat} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: score=%h bid=%0d valid=%0b w_en=%0b w_addr=%0d ovf=%0b sat=%0b want all 0",
               o_score, o_bid, o_valid, w_en, w_addr, ovf, sat);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (o_valid !== 1'b0 || w_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: valid=%0b w_en=%0b want 0 0", o_valid, w_en);
    end
  endtask

  task automatic test_positive();
    run_block(13'd5, F_ONE, F_ONE, F_ONE, F_ONE, W_ONE, 32'h24000000, 1'b0, "pos");
  endtask

  task automatic test_negative();
    run_block(13'd6, F_ONE, F_ONE, F_ONE, F_ONE, {36{16'hC000}}, 32'hDC000000, 1'b0, "neg");
  endtask

  // a: 1.0*1.0*9=9, b: 2.0*-1.0*9=-18, c: zero features, d: 0.5*0.5*9=2.25
  task automatic test_cells();
    run_block(13'd4095, F_ONE, {9{32'h20000000}}, '0, {9{32'h08000000}},
              {{9{16'h2000}}, {9{16'h4000}}, {9{16'hC000}}, {9{16'h4000}}},
              32'hF9400000, 1'b0, "cells");
  endtask

  task automatic test_floor();
    run_block(13'd8191, {9{32'h00000001}}, {9{32'h00000001}}, {9{32'h00000001}},
              {9{32'h00000001}}, {36{16'hFFFF}}, 32'hFFFFFFDC, 1'b0, "floor");
  endtask

  task automatic test_saturate();
    run_block(13'd1, {9{32'hFFFFFFFF}}, {9{32'hFFFFFFFF}}, {9{32'hFFFFFFFF}},
              {9{32'hFFFFFFFF}}, {36{16'h7FFF}}, 32'h7FFFFFFF, 1'b1, "sat_pos");
    run_block(13'd2, {9{32'hFFFFFFFF}}, {9{32'hFFFFFFFF}}, {9{32'hFFFFFFFF}},
              {9{32'hFFFFFFFF}}, {36{16'h8000}}, 32'h80000000, 1'b1, "sat_neg");
  endtask

  // Strobes at cycles 0 (bid 7), 6 (bid 9, accepted in OUT), 9 (bid 11, dropped).
  task automatic test_back_to_back();
    rom_word = W_ONE;
    set_fea(F_ONE, F_ONE, F_ONE, F_ONE);
    for (int c = 0; c < 20; c++) begin
      total++;
      if (o_valid !== ((c == 6) || (c == 12))) begin
        bad++;
        $display("FAIL b2b_valid: cycle %0d o_valid=%0b want %0b", c, o_valid, (c == 6) || (c == 12));
      end
      total++;
      if (w_en !== ((c == 1) || (c == 7))) begin
        bad++;
        $display("FAIL b2b_wen: cycle %0d w_en=%0b want %0b", c, w_en, (c == 1) || (c == 7));
      end
      if (c == 7) begin
        total++;
        if (w_addr !== 13'd9) begin
          bad++;
          $display("FAIL b2b_addr: w_addr=%0d want 9", w_addr);
        end
      end
      if (c == 6 || c == 9) begin
        total++;
        if (ovf !== 1'b0) begin
          bad++;
          $display("FAIL b2b_ovf_early: cycle %0d ovf=%0b want 0", c, ovf);
        end
      end
      if (c == 6) begin
        total++;
        if (o_bid !== 13'd7 || o_score !== 32'h24000000) begin
          bad++;
          $display("FAIL b2b_first: bid=%0d score=%h want 7 24000000", o_bid, o_score);
        end
      end
      if (c == 12) begin
        total++;
        if (o_bid !== 13'd9 || o_score !== 32'h24000000 || ovf !== 1'b1) begin
          bad++;
          $display("FAIL b2b_second: bid=%0d score=%h ovf=%0b want 9 24000000 1", o_bid, o_score, ovf);
        end
      end
      i_valid = (c == 0) || (c == 6) || (c == 9);
      bid     = (c == 0) ? 13'd7 : (c == 6) ? 13'd9 : 13'd11;
      if (c == 9) set_fea('0, '0, '0, '0);
      else        set_fea(F_ONE, F_ONE, F_ONE, F_ONE);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic test_rst_mid();
    // rst and i_valid together: nothing captured, flags cleared.
    rom_word = W_ONE;
    bid = 13'd3;
    set_fea(F_ONE, F_ONE, F_ONE, F_ONE);
    rst = 1'b1; i_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    total++;
    if (w_en !== 1'b0 || ovf !== 1'b0 || sat !== 1'b0) begin
      bad++;
      $display("FAIL rst_wins: w_en=%0b ovf=%0b sat=%0b want 0 0 0", w_en, ovf, sat);
    end
    // Reset at T+3 aborts the in-flight block.
    for (int c = 0; c < 13; c++) begin
      total++;
      if (o_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_valid: cycle %0d o_valid=%0b want 0", c, o_valid);
      end
      i_valid = (c == 0);
      rst     = (c == 3);
      @(posedge clk); #1;
    end
    i_valid = 1'b0; rst = 1'b0;
    run_block(13'd4, F_ONE, F_ONE, F_ONE, F_ONE, W_ONE, 32'h24000000, 1'b0, "after_rst");
    total++;
    if (ovf !== 1'b0 || sat !== 1'b0) begin
      bad++;
      $display("FAIL after_rst_flags: ovf=%0b sat=%0b want 0 0", ovf, sat);
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_cells();
    test_floor();
    test_back_to_back();
    test_saturate();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
